// File: rtl/axi_line_master.sv
// AXI4 burst master moving whole cache lines: refills as INCR read bursts,
// write-backs as INCR write bursts, one transaction at a time.
module axi_line_master #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wr,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    output logic [$clog2(LINE_WORDS)-1:0] wbuf_idx,
    input  logic [DATA_WIDTH-1:0]         wbuf_data,
    output logic                          rd_word_valid,
    output logic [$clog2(LINE_WORDS)-1:0] rd_word_idx,
    output logic [DATA_WIDTH-1:0]         rd_word_data,
    output logic                          done,
    output logic                          err,
    output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
    output logic [7:0]                    M_AXI_AWLEN,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
    output logic                          M_AXI_WVALID,
    output logic                          M_AXI_WLAST,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB, StDone} state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [IDX_W-1:0]        r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_err;
    logic                    w_accept;
    logic                    w_last;

    assign w_accept = (r_state == StIdle) && req_valid;
    assign w_last   = (r_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: if (req_valid) w_state_next = req_wr ? StAw : StAr;
            StAr:   if (M_AXI_ARREADY) w_state_next = StR;
            // Either a correct or a mis-framed burst end finishes the refill.
            StR:    if (M_AXI_RVALID && (M_AXI_RLAST || w_last)) w_state_next = StDone;
            StAw:   if (M_AXI_AWREADY) w_state_next = StW;
            StW:    if (M_AXI_WREADY && w_last) w_state_next = StB;
            StB:    if (M_AXI_BVALID) w_state_next = StDone;
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_addr <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                StR: begin
                    if (M_AXI_RVALID) begin
                        r_cnt <= r_cnt + IDX_W'(1);
                        if (M_AXI_RLAST != w_last) r_err <= 1'b1;
                    end
                end
                StW: if (M_AXI_WREADY) r_cnt <= r_cnt + IDX_W'(1);
                StB: if (M_AXI_BVALID) r_err <= |M_AXI_BRESP;
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready     = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_WLAST   = 1'b0;
        M_AXI_BREADY  = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        rd_word_valid = 1'b0;
        case (r_state)
            StIdle: req_ready = 1'b1;
            StAr:   M_AXI_ARVALID = 1'b1;
            StR: begin
                M_AXI_RREADY  = 1'b1;
                rd_word_valid = M_AXI_RVALID;
            end
            StAw:   M_AXI_AWVALID = 1'b1;
            StW: begin
                M_AXI_WVALID = 1'b1;
                M_AXI_WLAST  = w_last;
            end
            StB:    M_AXI_BREADY = 1'b1;
            StDone: begin
                done = 1'b1;
                err  = r_err;
            end
            default: ;
        endcase
    end

    assign M_AXI_AWADDR = r_addr;
    assign M_AXI_ARADDR = r_addr;
    assign M_AXI_AWLEN  = 8'(LINE_WORDS - 1);
    assign M_AXI_ARLEN  = 8'(LINE_WORDS - 1);
    assign M_AXI_WDATA  = wbuf_data;
    assign wbuf_idx     = r_cnt;
    assign rd_word_idx  = r_cnt;
    assign rd_word_data = M_AXI_RDATA;

endmodule

// File: tb/tb_axi_line_master.sv
// Directed bench for axi_line_master: the bench plays both the cache and the
// AXI slave cycle by cycle, with expected values fixed by hand.
module tb_axi_line_master;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr;
    logic [1:0]  wbuf_idx;
    logic [31:0] wbuf_data;
    logic        rd_word_valid;
    logic [1:0]  rd_word_idx;
    logic [31:0] rd_word_data;
    logic        done, err;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  awlen, arlen;
    logic        awvalid, awready, wvalid, wlast, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready, arvalid, arready, rlast, rvalid, rready;

    int total = 0;
    int bad   = 0;
    logic [31:0] ram [64];
    logic [31:0] wline [4];

    always #5 clk = ~clk;

    always_comb wbuf_data = wline[wbuf_idx];

    axi_line_master #(.LINE_WORDS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
        .wbuf_idx(wbuf_idx), .wbuf_data(wbuf_data),
        .rd_word_valid(rd_word_valid), .rd_word_idx(rd_word_idx), .rd_word_data(rd_word_data),
        .done(done), .err(err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WVALID(wvalid), .M_AXI_WLAST(wlast), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    task automatic idle_inputs();
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%0b want=1", req_ready); end
        total++; if ({arvalid, awvalid, wvalid, bready, rready} !== 5'b0) begin
            bad++; $display("FAIL rst_channel_ctl got=%b want=00000", {arvalid, awvalid, wvalid, bready, rready});
        end
        total++; if ({done, rd_word_valid} !== 2'b00) begin
            bad++; $display("FAIL rst_done_rdv got=%b want=00", {done, rd_word_valid});
        end
        total++; if (awlen !== 8'd3 || arlen !== 8'd3) begin
            bad++; $display("FAIL rst_len got=%0d/%0d want=3/3", awlen, arlen);
        end
        total++; if (araddr !== 32'h0 || wbuf_idx !== 2'd0) begin
            bad++; $display("FAIL rst_addr_idx got=%h/%0d want=0/0", araddr, wbuf_idx);
        end
        @(negedge clk); resetn = 1'b1; #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0b want=1", req_ready); end
    endtask

    // Refill of the line holding addr; the slave asserts RLAST on beat last_beat.
    task automatic run_refill(input logic [31:0] addr, input int last_beat);
        logic [31:0] base;
        logic        exp_err;
        base    = addr & ~32'hF;
        exp_err = (last_beat != 3);
        @(negedge clk); req_valid = 1'b1; req_wr = 1'b0; req_addr = addr; #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rf_accept_ready got=%0b want=1", req_ready); end
        @(negedge clk); req_valid = 1'b0; arready = 1'b1; #1;
        total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL rf_arvalid got=%0b want=1", arvalid); end
        total++; if (araddr !== base) begin bad++; $display("FAIL rf_araddr got=%h want=%h", araddr, base); end
        total++; if (arlen !== 8'd3) begin bad++; $display("FAIL rf_arlen got=%0d want=3", arlen); end
        for (int k = 0; k <= last_beat; k++) begin
            @(negedge clk); arready = 1'b0; rvalid = 1'b1;
            rdata = ram[int'(base >> 2) + k]; rlast = (k == last_beat); #1;
            total++; if (rd_word_valid !== 1'b1 || rready !== 1'b1) begin
                bad++; $display("FAIL rf_beat%0d_strobe got=%b want=11", k, {rd_word_valid, rready});
            end
            total++; if (rd_word_idx !== 2'(k)) begin
                bad++; $display("FAIL rf_beat%0d_idx got=%0d want=%0d", k, rd_word_idx, k);
            end
            total++; if (rd_word_data !== 32'h1000_0000 + (base >> 2) + 32'(k)) begin
                bad++; $display("FAIL rf_beat%0d_data got=%h want=%h", k, rd_word_data,
                                32'h1000_0000 + (base >> 2) + 32'(k));
            end
        end
        // A stray beat during DONE must not be forwarded.
        @(negedge clk); rvalid = 1'b1; rlast = 1'b0; rdata = 32'hDEAD_BEEF; #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rf_done got=%0b want=1", done); end
        total++; if (err !== exp_err) begin bad++; $display("FAIL rf_err got=%0b want=%0b", err, exp_err); end
        total++; if ({rd_word_valid, rready, req_ready} !== 3'b000) begin
            bad++; $display("FAIL rf_done_quiet got=%b want=000", {rd_word_valid, rready, req_ready});
        end
        @(negedge clk); rvalid = 1'b0; #1;
        total++; if (done !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL rf_back_idle got=%b want=01", {done, req_ready});
        end
    endtask

    task automatic test_refill();
        run_refill(32'h0000_0014, 3);
    endtask

    task automatic test_rlast_early();
        run_refill(32'h0000_0020, 1);
        run_refill(32'h0000_0030, 3);
    endtask

    // Write-back with AWREADY held off aw_wait cycles and WREADY toggling 1-0-1-0.
    task automatic run_writeback(input logic [31:0] addr, input logic [1:0] resp,
                                 input int aw_wait, input logic exp_err);
        int exp_idx;
        @(negedge clk); req_valid = 1'b1; req_wr = 1'b1; req_addr = addr; #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL wb_accept_ready got=%0b want=1", req_ready); end
        for (int i = 0; i < aw_wait; i++) begin
            @(negedge clk); req_valid = 1'b0; awready = 1'b0; #1;
            total++; if (awvalid !== 1'b1 || wvalid !== 1'b0) begin
                bad++; $display("FAIL wb_aw_wait%0d got=%b want=10", i, {awvalid, wvalid});
            end
            total++; if (awaddr !== addr || awlen !== 8'd3) begin
                bad++; $display("FAIL wb_aw_wait%0d_addr got=%h/%0d want=%h/3", i, awaddr, awlen, addr);
            end
        end
        @(negedge clk); req_valid = 1'b0; awready = 1'b1; #1;
        total++; if (awvalid !== 1'b1 || wvalid !== 1'b0) begin
            bad++; $display("FAIL wb_aw_hs got=%b want=10", {awvalid, wvalid});
        end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk); awready = 1'b0; wready = (c % 2 == 0); #1;
            exp_idx = (c + 1) / 2;
            total++; if (wvalid !== 1'b1 || awvalid !== 1'b0) begin
                bad++; $display("FAIL wb_w%0d_valid got=%b want=10", c, {wvalid, awvalid});
            end
            total++; if (wbuf_idx !== 2'(exp_idx)) begin
                bad++; $display("FAIL wb_w%0d_idx got=%0d want=%0d", c, wbuf_idx, exp_idx);
            end
            total++; if (wlast !== (exp_idx == 3)) begin
                bad++; $display("FAIL wb_w%0d_wlast got=%0b want=%0b", c, wlast, exp_idx == 3);
            end
            if (wready && wvalid) ram[int'(addr >> 2) + exp_idx] = wdata;
        end
        @(negedge clk); wready = 1'b0; bvalid = 1'b1; bresp = resp; #1;
        total++; if (bready !== 1'b1 || wvalid !== 1'b0) begin
            bad++; $display("FAIL wb_b got=%b want=10", {bready, wvalid});
        end
        @(negedge clk); bvalid = 1'b0; bresp = 2'b00; #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL wb_done got=%0b want=1", done); end
        total++; if (err !== exp_err) begin bad++; $display("FAIL wb_err got=%0b want=%0b", err, exp_err); end
        total++; if (bready !== 1'b0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL wb_done_quiet got=%b want=00", {bready, req_ready});
        end
        @(negedge clk); #1;
        total++; if (done !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL wb_back_idle got=%b want=01", {done, req_ready});
        end
        for (int j = 0; j < 4; j++) begin
            total++; if (ram[int'(addr >> 2) + j] !== wline[j]) begin
                bad++; $display("FAIL wb_ram%0d got=%h want=%h", j, ram[int'(addr >> 2) + j], wline[j]);
            end
        end
    endtask

    task automatic test_writeback();
        for (int j = 0; j < 4; j++) wline[j] = 32'hCAFE_0000 + 32'(j);
        run_writeback(32'h0000_0040, 2'b00, 5, 1'b0);
    endtask

    task automatic test_bresp_err();
        for (int j = 0; j < 4; j++) wline[j] = 32'hBAD0_0000 + 32'(j);
        run_writeback(32'h0000_0080, 2'b10, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        @(negedge clk); req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h0; #1;
        @(negedge clk); req_valid = 1'b0; awready = 1'b1; #1;
        total++; if (awvalid !== 1'b1) begin bad++; $display("FAIL rm_awvalid got=%0b want=1", awvalid); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); awready = 1'b0; wready = 1'b1; #1;
            total++; if (wvalid !== 1'b1 || wbuf_idx !== 2'(c)) begin
                bad++; $display("FAIL rm_w%0d got=%b/%0d want=1/%0d", c, wvalid, wbuf_idx, c);
            end
        end
        @(negedge clk); wready = 1'b0; resetn = 1'b0; #1;
        total++; if ({wvalid, bready, done, awvalid} !== 4'b0000) begin
            bad++; $display("FAIL rm_drop got=%b want=0000", {wvalid, bready, done, awvalid});
        end
        total++; if (wbuf_idx !== 2'd0) begin bad++; $display("FAIL rm_idx got=%0d want=0", wbuf_idx); end
        @(negedge clk); resetn = 1'b1; #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%0b want=1", req_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (done) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL rm_no_done got=%0d want=0", pulses); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        @(negedge clk); req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h00; #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bb_ready0 got=%0b want=1", req_ready); end
        @(negedge clk); req_addr = 32'h10; arready = 1'b1; #1;
        total++; if (arvalid !== 1'b1 || araddr !== 32'h00) begin
            bad++; $display("FAIL bb_ar0 got=%b/%h want=1/00000000", arvalid, araddr);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); arready = 1'b0; rvalid = 1'b1; rdata = ram[k]; rlast = (k == 3); #1;
            total++; if (rd_word_idx !== 2'(k) || rd_word_data !== 32'h1000_0000 + 32'(k)) begin
                bad++; $display("FAIL bb_r0_%0d got=%0d/%h want=%0d/%h", k, rd_word_idx, rd_word_data,
                                k, 32'h1000_0000 + 32'(k));
            end
        end
        @(negedge clk); rvalid = 1'b0; rlast = 1'b0; #1;
        if (done) pulses++;
        total++; if ({done, err, req_ready} !== 3'b100) begin
            bad++; $display("FAIL bb_done0 got=%b want=100", {done, err, req_ready});
        end
        @(negedge clk); #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bb_ready1 got=%0b want=1", req_ready); end
        @(negedge clk); req_valid = 1'b0; arready = 1'b1; #1;
        total++; if (arvalid !== 1'b1 || araddr !== 32'h10) begin
            bad++; $display("FAIL bb_ar1 got=%b/%h want=1/00000010", arvalid, araddr);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); arready = 1'b0; rvalid = 1'b1; rdata = ram[4 + k]; rlast = (k == 3); #1;
            total++; if (rd_word_idx !== 2'(k) || rd_word_data !== 32'h1000_0004 + 32'(k)) begin
                bad++; $display("FAIL bb_r1_%0d got=%0d/%h want=%0d/%h", k, rd_word_idx, rd_word_data,
                                k, 32'h1000_0004 + 32'(k));
            end
        end
        @(negedge clk); rvalid = 1'b0; rlast = 1'b0; #1;
        if (done) pulses++;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL bb_err1 got=%0b want=0", err); end
        @(negedge clk); #1;
        if (done) pulses++;
        total++; if (pulses !== 2) begin bad++; $display("FAIL bb_pulses got=%0d want=2", pulses); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h1000_0000 + 32'(i);
        for (int j = 0; j < 4; j++) wline[j] = '0;
        test_reset();
        test_refill();
        test_writeback();
        test_bresp_err();
        test_rlast_early();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
